// File: rtl/spi_slave_bridge.sv
// spi_slave_bridge: SPI mode-0 slave moving tagged words between a host and core-side FIFOs
module spi_slave_bridge #(
  parameter int W = 32,
  parameter int TAG_W = 4,
  parameter int TX_DEPTH = 64,
  parameter int RX_DEPTH = 16,
  parameter int URGENT_LVL = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         spi_clk,
  input  logic         spi_mosi,
  input  logic         spi_cs,
  output logic         spi_miso,
  output logic         gpio_rd_valid,
  output logic         gpio_rd_urgent,
  input  logic         gpio_rd_cntreq,
  input  logic         wr_en,
  input  logic [W-1:0] wr_din,
  output logic         wr_full,
  input  logic         rd_en,
  output logic         rd_rdy,
  output logic [W-1:0] rd_dout,
  output logic [7:0]   rx_ovf_cnt,
  output logic [7:0]   short_cnt
);
  localparam int CNT_W = $clog2(TX_DEPTH + 1);
  localparam int SH_W = W - TAG_W - 4 - CNT_W;
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = $clog2(RX_DEPTH + 1);
  localparam int BC_W = $clog2(W + 1);
  typedef enum logic [1:0] {S_IDLE, S_FIFO, S_STAT} src_t;
  logic [2:0] sck_s, cs_s, cr_s;
  logic [1:0] mosi_s;
  logic armed, active, stat_pending, status_ok;
  logic [BC_W-1:0] bit_cnt;
  logic [W-1:0] tx_sh, rx_sh, stat_word, load_word;
  src_t src, sel;
  logic [SH_W-1:0] shadow;
  logic [CNT_W-1:0] cnt_snap, snap_n, tx_cnt, avail;
  logic [W-1:0] tx_mem [TX_DEPTH];
  logic [W-1:0] rx_mem [RX_DEPTH];
  logic [TX_AW-1:0] tx_wp, tx_rp;
  logic [RX_AW-1:0] rx_wp, rx_rp;
  logic [RX_CW-1:0] rx_cnt;
  logic sck_rise, sck_fall, cs_fall, cs_rise, cr_edge, done, pop_tx, push_tx;
  logic push_rx, push_rx_ok, pop_rx, stat_n;
  // Edge pulses, FIFO handshakes and the next TX word as seen after this cycle's pop/request
  always_comb begin
    sck_rise = sck_s[1] & ~sck_s[2];
    sck_fall = ~sck_s[1] & sck_s[2];
    cs_fall = armed & ~cs_s[1] & cs_s[2];
    cs_rise = cs_s[1] & ~cs_s[2];
    cr_edge = cr_s[1] ^ cr_s[2];
    done = active & (bit_cnt == BC_W'(W));
    pop_tx = done & (src == S_FIFO);
    push_tx = wr_en & (|wr_din[W-1 -: TAG_W]) & (tx_cnt != CNT_W'(TX_DEPTH));
    push_rx = done & (|rx_sh[W-1 -: TAG_W]);
    push_rx_ok = push_rx & (rx_cnt != RX_CW'(RX_DEPTH));
    rd_rdy = rx_cnt != '0;
    pop_rx = rd_en & rd_rdy;
    rd_dout = rd_rdy ? rx_mem[rx_rp] : '0;
    stat_n = cr_edge | (stat_pending & ~(done & (src == S_STAT)));
    snap_n = cr_edge ? tx_cnt : cnt_snap;
    avail = tx_cnt - CNT_W'(pop_tx);
    sel = stat_n ? S_STAT : (avail != '0) ? S_FIFO : S_IDLE;
    stat_word = {{TAG_W{1'b0}}, 1'b1, sel == S_STAT, avail == '0, status_ok,
                 (sel == S_STAT) ? snap_n : avail, shadow};
    load_word = (sel == S_FIFO) ? tx_mem[tx_rp + TX_AW'(pop_tx)] : stat_word;
  end
  // Request line is a free-running toggle; its chain needs no reset
  always_ff @(posedge clk) cr_s <= {cr_s[1:0], gpio_rd_cntreq};
  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_tx) tx_mem[tx_wp] <= wr_din;
    if (push_rx_ok) rx_mem[rx_wp] <= rx_sh;
  end
  // Pin synchronisers, frame engine, FIFO pointers, status capture and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s <= '0;
      cs_s <= '0;
      mosi_s <= '0;
      armed <= 1'b0;
      active <= 1'b0;
      bit_cnt <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      src <= S_IDLE;
      stat_pending <= 1'b0;
      status_ok <= 1'b0;
      shadow <= '0;
      cnt_snap <= '0;
      tx_cnt <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
      rx_cnt <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      rx_ovf_cnt <= '0;
      short_cnt <= '0;
      spi_miso <= 1'b0;
      gpio_rd_valid <= 1'b0;
      gpio_rd_urgent <= 1'b0;
      wr_full <= 1'b0;
    end else begin
      sck_s <= {sck_s[1:0], spi_clk};
      cs_s <= {cs_s[1:0], spi_cs};
      mosi_s <= {mosi_s[0], spi_mosi};
      armed <= armed | cs_rise;
      stat_pending <= stat_n;
      cnt_snap <= snap_n;
      spi_miso <= active & tx_sh[W-1];
      if (done) begin
        bit_cnt <= '0;
        tx_sh <= load_word;
        src <= sel;
      end else if (active & sck_rise) begin
        bit_cnt <= bit_cnt + 1'b1;
        rx_sh <= {rx_sh[W-2:0], mosi_s[1]};
      end else if (active & sck_fall & (bit_cnt != '0)) begin
        tx_sh <= {tx_sh[W-2:0], 1'b0};
      end
      if (cs_fall) begin
        active <= 1'b1;
        bit_cnt <= '0;
        tx_sh <= load_word;
        src <= sel;
      end
      if (active & cs_rise) begin
        active <= 1'b0;
        bit_cnt <= '0;
        if (!done && bit_cnt != '0 && short_cnt != 8'hFF) short_cnt <= short_cnt + 8'd1;
      end
      if (wr_en & ~|wr_din[W-1 -: TAG_W]) begin
        shadow <= wr_din[SH_W-1:0];
        status_ok <= 1'b1;
      end
      tx_cnt <= tx_cnt + CNT_W'(push_tx) - CNT_W'(pop_tx);
      tx_wp <= tx_wp + TX_AW'(push_tx);
      tx_rp <= tx_rp + TX_AW'(pop_tx);
      gpio_rd_valid <= tx_cnt != '0;
      gpio_rd_urgent <= tx_cnt >= CNT_W'(URGENT_LVL);
      wr_full <= tx_cnt == CNT_W'(TX_DEPTH);
      rx_cnt <= rx_cnt + RX_CW'(push_rx_ok) - RX_CW'(pop_rx);
      rx_wp <= rx_wp + RX_AW'(push_rx_ok);
      rx_rp <= rx_rp + RX_AW'(pop_rx);
      if (push_rx & ~push_rx_ok & (rx_ovf_cnt != 8'hFF)) rx_ovf_cnt <= rx_ovf_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_spi_slave_bridge.sv
// tb_spi_slave_bridge: directed self-checking bench for spi_slave_bridge
module tb_spi_slave_bridge;
  logic clk = 0, rst = 1, spi_clk = 0, spi_mosi = 0, spi_cs = 1, spi_miso;
  logic gpio_rd_valid, gpio_rd_urgent, gpio_rd_cntreq = 0;
  logic wr_en = 0, wr_full, rd_en = 0, rd_rdy;
  logic [31:0] wr_din = 0, rd_dout, mi, m0, m1, m2;
  logic [7:0] rx_ovf_cnt, short_cnt;
  int checks = 0, passed = 0, hp = 40, n;
  spi_slave_bridge dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_miso(spi_miso), .gpio_rd_valid(gpio_rd_valid), .gpio_rd_urgent(gpio_rd_urgent),
    .gpio_rd_cntreq(gpio_rd_cntreq), .wr_en(wr_en), .wr_din(wr_din), .wr_full(wr_full),
    .rd_en(rd_en), .rd_rdy(rd_rdy), .rd_dout(rd_dout), .rx_ovf_cnt(rx_ovf_cnt),
    .short_cnt(short_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic send_bits(input logic [31:0] mo, input int nb, output logic [31:0] mi_o);
    mi_o = '0;
    for (int i = 31; i > 31 - nb; i--) begin
      spi_mosi = mo[i];
      #(hp) mi_o[i] = spi_miso;
      spi_clk = 1;
      #(hp) spi_clk = 0;
    end
  endtask
  task automatic cs_lo;
    spi_cs = 0;
    #100;
  endtask
  task automatic cs_hi;
    #100 spi_cs = 1;
    #100;
  endtask
  task automatic frame(input logic [31:0] mo, output logic [31:0] mi_o);
    cs_lo();
    send_bits(mo, 32, mi_o);
    cs_hi();
  endtask
  task automatic wr(input logic [31:0] d);
    @(negedge clk);
    wr_en = 1;
    wr_din = d;
    @(negedge clk);
    wr_en = 0;
  endtask
  task automatic rd_pop;
    @(negedge clk);
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
  endtask
  initial begin
    repeat (5) @(negedge clk);
    check("reset_flags", {31'd0, spi_miso | gpio_rd_valid | gpio_rd_urgent | wr_full | rd_rdy}, 32'd0);
    check("reset_dout", rd_dout, 32'd0);
    check("reset_cnts", {16'd0, rx_ovf_cnt, short_cnt}, 32'd0);
    rst = 0;
    repeat (5) @(negedge clk);
    // single word exchange
    wr(32'h1234_5678);
    repeat (3) @(negedge clk);
    check("valid_after_write", {31'd0, gpio_rd_valid}, 32'd1);
    frame(32'hA000_0001, mi);
    check("t1_miso", mi, 32'h1234_5678);
    check("t1_rd_rdy", {31'd0, rd_rdy}, 32'd1);
    check("t1_rd_dout", rd_dout, 32'hA000_0001);
    check("t1_valid_drop", {31'd0, gpio_rd_valid}, 32'd0);
    rd_pop();
    check("t1_rx_empty", {31'd0, rd_rdy}, 32'd0);
    // status request with three words queued
    wr(32'h0000_0ABC);
    wr(32'h1111_1111);
    wr(32'h2222_2222);
    wr(32'h3333_3333);
    repeat (3) @(negedge clk);
    gpio_rd_cntreq = 1;
    repeat (8) @(negedge clk);
    frame(32'h0000_0000, mi);
    check("t2_stat_word", mi, 32'h0D06_0ABC);
    check("t2_tag0_discard", {31'd0, rd_rdy}, 32'd0);
    frame(32'h0000_0000, mi);
    check("t2_fifo_head", mi, 32'h1111_1111);
    // short frame, then resend
    cs_lo();
    send_bits(32'hB000_0000, 17, mi);
    cs_hi();
    check("t3_short_cnt", {24'd0, short_cnt}, 32'd1);
    check("t3_no_rx", {31'd0, rd_rdy}, 32'd0);
    frame(32'h0000_0000, mi);
    check("t3_resend", mi, 32'h2222_2222);
    // 96-bit burst with two words queued
    wr(32'h4444_4444);
    cs_lo();
    send_bits(32'hC000_0001, 32, m0);
    send_bits(32'hD000_0002, 32, m1);
    send_bits(32'hE000_0003, 32, m2);
    cs_hi();
    check("t4_word0", m0, 32'h3333_3333);
    check("t4_word1", m1, 32'h4444_4444);
    check("t4_idle", m2, 32'h0B00_0ABC);
    check("t4_rx0", rd_dout, 32'hC000_0001);
    rd_pop();
    check("t4_rx1", rd_dout, 32'hD000_0002);
    rd_pop();
    check("t4_rx2", rd_dout, 32'hE000_0003);
    rd_pop();
    check("t4_rx_empty", {31'd0, rd_rdy}, 32'd0);
    check("t4_short_kept", {24'd0, short_cnt}, 32'd1);
    // RX overflow and saturation
    cs_lo();
    for (int k = 0; k < 18; k++) send_bits(32'h2000_0000 + k, 32, mi);
    cs_hi();
    check("t5_ovf2", {24'd0, rx_ovf_cnt}, 32'd2);
    cs_lo();
    for (int k = 0; k < 256; k++) send_bits(32'h3000_0000 + k, 32, mi);
    cs_hi();
    check("t5_ovf_sat", {24'd0, rx_ovf_cnt}, 32'd255);
    check("t5_first_kept", rd_dout, 32'h2000_0000);
    n = 0;
    for (int i = 0; i < 40 && rd_rdy; i++) begin
      rd_pop();
      n++;
    end
    check("t5_stored", n, 16);
    // reset in the middle of a frame
    wr(32'h5555_5555);
    cs_lo();
    send_bits(32'h7000_0000, 10, mi);
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    check("t6_rst_flags", {31'd0, spi_miso | gpio_rd_valid | gpio_rd_urgent | wr_full | rd_rdy}, 32'd0);
    check("t6_rst_cnts", {16'd0, rx_ovf_cnt, short_cnt}, 32'd0);
    rst = 0;
    send_bits(32'h7000_0000, 22, mi);
    cs_hi();
    check("t6_ignored", {23'd0, rd_rdy, short_cnt}, 32'd0);
    wr(32'h6666_6666);
    frame(32'hF000_0005, mi);
    check("t6_resume_miso", mi, 32'h6666_6666);
    check("t6_resume_rx", rd_dout, 32'hF000_0005);
    // urgent and full flags
    for (int k = 0; k < 47; k++) wr(32'h1000_0000 + k);
    repeat (3) @(negedge clk);
    check("t7_not_urgent", {30'd0, gpio_rd_urgent, wr_full}, 32'd0);
    wr(32'h1000_00FF);
    repeat (3) @(negedge clk);
    check("t7_urgent", {30'd0, gpio_rd_urgent, wr_full}, 32'd2);
    for (int k = 0; k < 16; k++) wr(32'h1100_0000 + k);
    repeat (3) @(negedge clk);
    check("t7_full", {30'd0, gpio_rd_urgent, wr_full}, 32'd3);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
